// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - multicycle instruction sequencer: IF/ID/EXE/MEM/WB/HALT control and retire count
module pc_sequencer #(
  parameter logic [5:0] HALT_OP       = 6'b111111,
  parameter bit         ILLEGAL_HALTS = 1'b1
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [5:0]  Opcode,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        PCWre,
  output logic [1:0]  PCSrc,
  output logic        IRWre,
  output logic        RegWre,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [2:0]  State,
  output logic [31:0] RetireCount
);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b111
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  state_t      state;
  state_t      nxt;
  logic [5:0]  op_q;
  logic [5:0]  op;
  logic        is_jump;
  logic        is_branch;
  logic        is_mem;
  logic        is_exe;
  logic        taken;
  logic [31:0] retire_q;

  always_comb begin
    nxt      = S_IF;
    PCWre    = 1'b0;
    PCSrc    = 2'b00;
    IRWre    = 1'b0;
    RegWre   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    // Decode the live opcode in ID; later states use the copy captured when leaving ID
    op        = (state == S_ID) ? Opcode : op_q;
    is_jump   = (op == OP_J) || (op == OP_JAL);
    is_branch = (op == OP_BEQ) || (op == OP_BNE);
    is_mem    = (op == OP_LW) || (op == OP_SW);
    is_exe    = (op == OP_R) || (op == OP_ADDI) || is_branch || is_mem;
    taken     = ((op == OP_BEQ) && Zero) || ((op == OP_BNE) && !Zero);

    case (state)
      S_IF: begin
        IRWre = MemReady;
        nxt   = MemReady ? S_ID : S_IF;
      end
      S_ID: begin
        if (is_jump) begin
          PCWre  = 1'b1;
          PCSrc  = 2'b10;
          RegWre = (op == OP_JAL);
          nxt    = S_IF;
        end else if (op == HALT_OP) begin
          nxt = S_HALT;
        end else if (is_exe) begin
          nxt = S_EXE;
        end else if (ILLEGAL_HALTS) begin
          nxt = S_HALT;
        end else begin
          PCWre = 1'b1;
          nxt   = S_IF;
        end
      end
      S_EXE: begin
        if (is_mem) begin
          nxt = S_MEM;
        end else if (is_branch) begin
          PCWre = 1'b1;
          PCSrc = taken ? 2'b01 : 2'b00;
          nxt   = S_IF;
        end else begin
          nxt = S_WB;
        end
      end
      S_MEM: begin
        MemRead  = (op == OP_LW);
        MemWrite = (op == OP_SW);
        if (!MemReady) begin
          nxt = S_MEM;
        end else if (op == OP_LW) begin
          nxt = S_WB;
        end else begin
          PCWre = 1'b1;
          nxt   = S_IF;
        end
      end
      S_WB: begin
        RegWre = 1'b1;
        PCWre  = 1'b1;
        nxt    = S_IF;
      end
      S_HALT: begin
        PCSrc = 2'b11;
        nxt   = S_HALT;
      end
      default: nxt = S_IF;
    endcase

    // While reset is held the sequencer presents quiet IF outputs regardless of MemReady
    if (Reset) begin
      nxt      = S_IF;
      PCWre    = 1'b0;
      PCSrc    = 2'b00;
      IRWre    = 1'b0;
      RegWre   = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state    <= S_IF;
      op_q     <= 6'b000000;
      retire_q <= 32'd0;
    end else begin
      state <= nxt;
      if (state == S_ID) op_q <= Opcode;
      // Entering HALT retires the halting instruction even though the PC is frozen
      if (PCWre || ((nxt == S_HALT) && (state != S_HALT))) retire_q <= retire_q + 32'd1;
    end
  end

  assign State       = state;
  assign RetireCount = retire_q;

endmodule
